// File: rtl/issue_queue_pkg.sv
// Shared types and constants for the issue queue.
//   issue_entry_t : one decoded-instruction payload
//   IQ_DEPTH      : default number of queue entries
//   IQ_OF_MARGIN  : free-entry threshold below which queue_of asserts
//   popClip()     : maps an issue-count request onto 0..2
package issue_queue_pkg;

  localparam int IQ_WIDTH     = 64;
  localparam int IQ_DEPTH     = 16;
  localparam int IQ_OF_MARGIN = 4;

  typedef logic [IQ_WIDTH-1:0] issue_entry_t;

  // Pop count 3 is illegal; it is treated as 2.
  function automatic logic [1:0] popClip(input logic [1:0] popN);
    return (popN == 2'd3) ? 2'd2 : popN;
  endfunction

endpackage

// File: rtl/iq_ram.sv
// DEPTH x WIDTH flop storage for the issue queue.
// Ports:
//   clk            : clock
//   we0, we1       : write enables; port 1 writes the address after port 0
//   wAddr          : base write address
//   wData0, wData1 : write data for wAddr and wAddr+1
//   rAddr          : base read address
//   rData0, rData1 : asynchronous reads of rAddr and rAddr+1
// Addresses wrap modulo DEPTH.
module iq_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we0,
  input  logic             we1,
  input  logic [PW-1:0]    wAddr,
  input  logic [WIDTH-1:0] wData0,
  input  logic [WIDTH-1:0] wData1,
  input  logic [PW-1:0]    rAddr,
  output logic [WIDTH-1:0] rData0,
  output logic [WIDTH-1:0] rData1
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wAddr1;
  logic [PW-1:0]    rAddr1;

  // Power-of-2 depth: pointer width overflow is the wrap.
  assign wAddr1 = wAddr + PW'(1);
  assign rAddr1 = rAddr + PW'(1);

  // The two write addresses are always distinct, so no port priority is needed.
  always_ff @(posedge clk) begin
    if (we0) mem[wAddr]  <= wData0;
    if (we1) mem[wAddr1] <= wData1;
  end

  assign rData0 = mem[rAddr];
  assign rData1 = mem[rAddr1];

endmodule

// File: rtl/issue_queue.sv
// Circular instruction buffer between dual decode and in-order dual issue.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   flush                   : squash all entries
//   stall                   : issue stalled, pop_n ignored
//   push_valid, push_data*  : up to two new instructions (bit0/data0 older)
//   pop_n                   : entries issued this cycle (3 illegal -> 2)
//   head_valid, head_data*  : oldest two entries
//   count, empty            : occupancy
//   queue_of                : fewer than OF_MARGIN free entries (stall fetch)
//   err_overflow            : sticky, dropped push or illegal pop_n
// All outputs depend on registered state only.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH,
  parameter int WIDTH     = IQ_WIDTH,
  parameter int OF_MARGIN = IQ_OF_MARGIN,
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall,
  input  logic [1:0]       push_valid,
  input  logic [WIDTH-1:0] push_data0,
  input  logic [WIDTH-1:0] push_data1,
  input  logic [1:0]       pop_n,
  output logic [1:0]       head_valid,
  output logic [WIDTH-1:0] head_data0,
  output logic [WIDTH-1:0] head_data1,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             queue_of,
  output logic             err_overflow
);

  logic [PW-1:0] headPtr, tailPtr;
  logic [CW-1:0] countQ;
  logic          errQ;

  logic [1:0]    nPush, pushAcc, popReq, nPop;
  logic [CW-1:0] freeCnt;
  logic          pushDrop, pushOk, wrEn;

  assign nPush   = {1'b0, push_valid[0]} + {1'b0, push_valid[1]};
  assign freeCnt = CW'(DEPTH) - countQ;

  // All-or-nothing push; space freed by a same-cycle pop does not count.
  assign pushDrop = CW'(nPush) > freeCnt;
  assign pushOk   = (nPush != 2'd0) && !pushDrop;
  assign pushAcc  = pushOk ? nPush : 2'd0;

  // Pop is clipped to what was present at cycle start: no push->pop bypass.
  assign popReq = popClip(pop_n);
  always_comb begin
    nPop = popReq;
    if (stall)                      nPop = 2'd0;
    else if (CW'(popReq) > countQ)  nPop = countQ[1:0];
  end

  assign wrEn = pushOk && !flush && !reset;

  // A lone push_valid=10 is compacted into the tail slot.
  iq_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) uRam (
    .clk    (clk),
    .we0    (wrEn),
    .we1    (wrEn && (nPush == 2'd2)),
    .wAddr  (tailPtr),
    .wData0 ((push_valid == 2'b10) ? push_data1 : push_data0),
    .wData1 (push_data1),
    .rAddr  (headPtr),
    .rData0 (head_data0),
    .rData1 (head_data1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      countQ  <= '0;
      errQ    <= 1'b0;
    end else if (flush) begin
      // err flag survives a flush; only reset clears it.
      headPtr <= '0;
      tailPtr <= '0;
      countQ  <= '0;
    end else begin
      headPtr <= headPtr + PW'(nPop);
      tailPtr <= tailPtr + PW'(pushAcc);
      countQ  <= countQ + CW'(pushAcc) - CW'(nPop);
      if (pushDrop || (pop_n == 2'd3)) errQ <= 1'b1;
    end
  end

  assign count        = countQ;
  assign empty        = (countQ == '0);
  assign head_valid   = {countQ >= CW'(2), countQ != '0};
  assign queue_of     = freeCnt < CW'(OF_MARGIN);
  assign err_overflow = errQ;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: the driver pushes the expected post-edge
// state into a scoreboard tagged with its cycle; a negedge monitor compares.
module tb_issue_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1, flush = 1'b0, stall = 1'b0;
  logic [1:0]  push_valid = '0, pop_n = '0;
  logic [63:0] push_data0 = '0, push_data1 = '0;
  logic [1:0]  head_valid;
  logic [63:0] head_data0, head_data1;
  logic [4:0]  count;
  logic        empty, queue_of, err_overflow;

  issue_queue dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .push_valid(push_valid), .push_data0(push_data0), .push_data1(push_data1),
    .pop_n(pop_n), .head_valid(head_valid), .head_data0(head_data0),
    .head_data1(head_data1), .count(count), .empty(empty),
    .queue_of(queue_of), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle = cycle + 1;

  typedef struct {
    int          cyc;
    string       nm;
    int          cnt;
    logic [63:0] d0, d1;
    bit          useD0, useD1;
    bit          err, qof;
  } exp_t;

  exp_t sb[$];
  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Drive one cycle's inputs just after an edge; they act on the next edge.
  task automatic drive(input logic [1:0] pv, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] pn, input logic st, input logic fl, input logic rs);
    @(posedge clk); #1;
    push_valid = pv; push_data0 = a; push_data1 = b;
    pop_n = pn; stall = st; flush = fl; reset = rs;
  endtask

  task automatic expect_st(input string nm, input int cnt, input logic [63:0] a,
                           input logic [63:0] b, input bit uA, input bit uB,
                           input bit err, input bit qof);
    exp_t e;
    e.cyc = cycle + 1; e.nm = nm; e.cnt = cnt; e.d0 = a; e.d1 = b;
    e.useD0 = uA; e.useD1 = uB; e.err = err; e.qof = qof;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.nm, " cycle"}, 64'(cycle), 64'(e.cyc));
      chk({e.nm, " count"}, 64'(count), 64'(e.cnt));
      chk({e.nm, " head_valid"}, 64'(head_valid), {62'd0, e.cnt >= 2, e.cnt >= 1});
      chk({e.nm, " empty"}, 64'(empty), 64'(e.cnt == 0));
      chk({e.nm, " queue_of"}, 64'(queue_of), 64'(e.qof));
      chk({e.nm, " err_overflow"}, 64'(err_overflow), 64'(e.err));
      if (e.useD0) chk({e.nm, " head_data0"}, head_data0, e.d0);
      if (e.useD1) chk({e.nm, " head_data1"}, head_data1, e.d1);
    end
  end

  initial begin
    // 1: reset, basic push/pop
    drive(2'b00, 0, 0, 0, 0, 0, 1); expect_st("reset", 0, 0, 0, 0, 0, 0, 0);
    drive(2'b11, 64'hA, 64'hB, 0, 0, 0, 0); expect_st("pushAB", 2, 64'hA, 64'hB, 1, 1, 0, 0);
    drive(2'b00, 0, 0, 1, 0, 0, 0); expect_st("pop1", 1, 64'hB, 0, 1, 0, 0, 0);
    drive(2'b00, 0, 0, 1, 0, 0, 0); expect_st("pop1b", 0, 0, 0, 0, 0, 0, 0);

    // 2: fill, overflow margin, dropped push, full
    for (int i = 0; i < 7; i++) begin
      drive(2'b11, 64'h100 + 64'(2*i), 64'h101 + 64'(2*i), 0, 0, 0, 0);
      expect_st("fill", 2*(i+1), 64'h100, 64'h101, 1, 1, 0, (2*(i+1)) >= 13);
    end
    drive(2'b11, 64'h200, 64'h201, 2, 0, 0, 0); expect_st("pp2at14", 14, 64'h102, 64'h103, 1, 1, 0, 1);
    drive(2'b01, 64'h300, 0, 0, 0, 0, 0); expect_st("to15", 15, 64'h102, 64'h103, 1, 1, 0, 1);
    drive(2'b11, 64'h400, 64'h401, 0, 0, 0, 0); expect_st("drop2", 15, 64'h102, 0, 1, 0, 1, 1);
    drive(2'b01, 64'h500, 0, 0, 0, 0, 0); expect_st("full", 16, 64'h102, 0, 1, 0, 1, 1);
    drive(2'b01, 64'h600, 0, 0, 0, 0, 0); expect_st("dropFull", 16, 64'h102, 64'h103, 1, 1, 1, 1);
    drive(2'b11, 64'h1, 64'h2, 2, 0, 0, 1); expect_st("midReset", 0, 0, 0, 0, 0, 0, 0);

    // 3: walk pointers to 15 then wrap a pair
    drive(2'b01, 64'h700, 0, 0, 0, 0, 0); expect_st("walk0", 1, 64'h700, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 14; k++) begin
      drive(2'b01, 64'h700 + 64'(k), 0, 1, 0, 0, 0);
      expect_st("walk", 1, 64'h700 + 64'(k), 0, 1, 0, 0, 0);
    end
    drive(2'b00, 0, 0, 1, 0, 0, 0); expect_st("walkEnd", 0, 0, 0, 0, 0, 0, 0);
    drive(2'b11, 64'hAA, 64'hBB, 0, 0, 0, 0); expect_st("wrapXY", 2, 64'hAA, 64'hBB, 1, 1, 0, 0);
    drive(2'b00, 0, 0, 1, 0, 0, 0); expect_st("wrapPopX", 1, 64'hBB, 0, 1, 0, 0, 0);
    drive(2'b00, 0, 0, 1, 0, 0, 0); expect_st("wrapPopY", 0, 0, 0, 0, 0, 0, 0);

    // 4: flush beats push and pop
    drive(2'b11, 64'h801, 64'h802, 0, 0, 0, 0); expect_st("f2", 2, 64'h801, 64'h802, 1, 1, 0, 0);
    drive(2'b11, 64'h803, 64'h804, 0, 0, 0, 0); expect_st("f4", 4, 64'h801, 64'h802, 1, 1, 0, 0);
    drive(2'b01, 64'h805, 0, 0, 0, 0, 0); expect_st("f5", 5, 64'h801, 64'h802, 1, 1, 0, 0);
    drive(2'b11, 64'h806, 64'h807, 2, 0, 1, 0); expect_st("flush", 0, 0, 0, 0, 0, 0, 0);

    // 5: stall blocks pop; lone slot-1 push compacts
    drive(2'b01, 64'h900, 0, 0, 0, 0, 0); expect_st("s1", 1, 64'h900, 0, 1, 0, 0, 0);
    drive(2'b10, 64'hDEAD, 64'h901, 2, 1, 0, 0); expect_st("stallPush10", 2, 64'h900, 64'h901, 1, 1, 0, 0);
    drive(2'b00, 0, 0, 2, 0, 0, 0); expect_st("s0", 0, 0, 0, 0, 0, 0, 0);

    // 6: push and pop on empty, no bypass
    drive(2'b11, 64'hA1, 64'hA2, 2, 0, 0, 0); expect_st("noBypass", 2, 64'hA1, 64'hA2, 1, 1, 0, 0);

    // illegal pop_n=3, flag survives flush
    drive(2'b00, 0, 0, 3, 0, 0, 0); expect_st("pop3", 0, 0, 0, 0, 0, 1, 0);
    drive(2'b00, 0, 0, 0, 0, 1, 0); expect_st("flushKeepsErr", 0, 0, 0, 0, 0, 1, 0);
    drive(2'b01, 64'hB1, 0, 0, 0, 0, 0); expect_st("postFlush", 1, 64'hB1, 0, 1, 0, 1, 0);
    drive(2'b00, 0, 0, 0, 0, 0, 0); expect_st("idle", 1, 64'hB1, 0, 1, 0, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
